// File: rtl/downselect_mask_ctrl.sv
// Shadow channel mask (MAX_WORDS x 32) streamed to the downselect select FIFO as one tlast burst per commit.
// Optional DSEL_MASK_AUTOLOAD_EN: after reset, an all-pass mask is streamed before the block goes idle.
module downselect_mask_ctrl #(
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              commit,
    input  logic [ADDR_W-1:0] num_words_m1,
    input  logic              align_en,
    input  logic              frame_boundary,
    output logic              m_axis_select_tvalid,
    output logic [31:0]       m_axis_select_tdata,
    output logic              m_axis_select_tlast,
    input  logic              m_axis_select_tready,
    output logic              busy,
    output logic              wr_drop,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_STREAM, S_INIT} state_t;

`ifdef DSEL_MASK_AUTOLOAD_EN
    localparam state_t            RST_STATE = S_INIT;
    localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(MAX_WORDS - 1);
`else
    localparam state_t            RST_STATE = S_IDLE;
`endif

    logic [31:0] mem [MAX_WORDS];

    state_t            state_q, state_d;
    logic              tvalid_q, tvalid_d;
    logic [31:0]       tdata_q, tdata_d;
    logic              tlast_q, tlast_d;
    logic              busy_q, busy_d;
    logic              wr_drop_q, wr_drop_d;
    logic              done_q, done_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pend_len_q, pend_len_d;
    logic              pend_align_q, pend_align_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic              wr_accept;
    logic              hs;
    logic [ADDR_W-1:0] idx_nxt;
    logic [31:0]       word0;
    logic              start;
    logic [ADDR_W-1:0] start_len;
    logic              start_align;

    assign wr_accept = wr_en && (state_q == S_IDLE);
    assign hs        = tvalid_q && m_axis_select_tready;
    assign idx_nxt   = idx_q + ADDR_W'(1);
    // A write to word 0 in the commit cycle must appear in the burst's first beat.
    assign word0     = (wr_accept && (wr_addr == '0)) ? wr_data : mem[0];

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        pending_d    = pending_q;
        pend_len_d   = pend_len_q;
        pend_align_d = pend_align_q;
        len_d        = len_q;
        idx_d        = idx_q;
        done_d       = 1'b0;
        wr_drop_d    = wr_en && (state_q != S_IDLE);
        start        = 1'b0;
        start_len    = pend_len_q;
        start_align  = pend_align_q;

        // Commits while busy coalesce into a single pending request; the latest wins.
        if (commit && (state_q != S_IDLE)) begin
            pending_d    = 1'b1;
            pend_len_d   = num_words_m1;
            pend_align_d = align_en;
        end

        case (state_q)
            S_IDLE: begin
                if (commit) begin
                    start       = 1'b1;
                    start_len   = num_words_m1;
                    start_align = align_en;
                end else if (pending_q) begin
                    start = 1'b1;
                end
                if (start) begin
                    pending_d = 1'b0;
                    len_d     = start_len;
                    idx_d     = '0;
                    if (start_align) begin
                        state_d = S_ARM;
                    end else begin
                        state_d  = S_STREAM;
                        tvalid_d = 1'b1;
                        tdata_d  = word0;
                        tlast_d  = (start_len == '0);
                    end
                end
            end
            S_ARM: begin
                if (frame_boundary) begin
                    state_d  = S_STREAM;
                    tvalid_d = 1'b1;
                    tdata_d  = mem[0];
                    tlast_d  = (len_q == '0);
                end
            end
            S_STREAM: begin
                if (hs) begin
                    if (tlast_q) begin
                        state_d  = S_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                        idx_d    = '0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d   = idx_nxt;
                        tdata_d = mem[idx_nxt];
                        tlast_d = (idx_nxt == len_q);
                    end
                end
            end
`ifdef DSEL_MASK_AUTOLOAD_EN
            S_INIT: begin
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    tdata_d  = '1;
                    tlast_d  = (INIT_LAST == '0);
                end else if (hs) begin
                    if (tlast_q) begin
                        state_d  = S_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                        idx_d    = '0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d   = idx_nxt;
                        tlast_d = (idx_nxt == INIT_LAST);
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state_q      <= RST_STATE;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            wr_drop_q    <= 1'b0;
            done_q       <= 1'b0;
            pending_q    <= 1'b0;
            pend_len_q   <= '0;
            pend_align_q <= 1'b0;
            len_q        <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            busy_q       <= busy_d;
            wr_drop_q    <= wr_drop_d;
            done_q       <= done_d;
            pending_q    <= pending_d;
            pend_len_q   <= pend_len_d;
            pend_align_q <= pend_align_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
        end
    end

    assign m_axis_select_tvalid = tvalid_q;
    assign m_axis_select_tdata  = tdata_q;
    assign m_axis_select_tlast  = tlast_q;
    assign busy                 = busy_q;
    assign wr_drop              = wr_drop_q;
    assign done                 = done_q;

endmodule
